// File: rtl/int_gateway.sv
// -----------------------------------------------------------------------------
// int_gateway
//
// Interrupt gateway and pending array. Each of the NSRC sources gets its own
// input synchronizer, level/edge qualification, saturating edge counter and a
// claim/complete handshake. A source that has been claimed cannot pend again
// until its handler completes.
//
// Parameters
//   NSRC         number of interrupt sources (IDs 1..NSRC, ID 0 = none)
//   IDW          width of claim/complete IDs
//   SYNC_STAGES  synchronizer depth (>= 2)
//   ECNT_W       edge counter width, saturates at 2**ECNT_W-1
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   src_irq       raw asynchronous interrupt lines
//   src_mode      per-source mode: 1 = rising edge, 0 = level high
//   claim_vld     one-cycle claim strobe
//   claim_id      ID being claimed
//   complete_vld  one-cycle completion strobe
//   complete_id   ID being completed
//   pending       registered pending bits (bit ID-1)
//   inflight      registered claimed-not-completed bits (bit ID-1)
//   irq_any       OR of pending
// -----------------------------------------------------------------------------
module int_gateway #(
    parameter int NSRC        = 8,
    parameter int IDW         = $clog2(NSRC + 1),
    parameter int SYNC_STAGES = 2,
    parameter int ECNT_W      = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NSRC-1:0] src_irq,
    input  logic [NSRC-1:0] src_mode,
    input  logic            claim_vld,
    input  logic [IDW-1:0]  claim_id,
    input  logic            complete_vld,
    input  logic [IDW-1:0]  complete_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] inflight,
    output logic            irq_any
);

    // Encoding chosen so that pending and inflight are taken straight from
    // state flops: bit 0 is PEND, bit 1 is INFL.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PEND = 2'b01,
        INFL = 2'b10
    } gw_state_e;

    localparam logic [ECNT_W-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        localparam logic [IDW-1:0] OWN_ID = IDW'(i + 1);

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   p_q;
        logic                   rise;
        logic                   claim_hit;
        logic                   complete_hit;
        logic [ECNT_W-1:0]      cnt_q;
        logic [ECNT_W-1:0]      cnt_sat;
        logic [ECNT_W-1:0]      cnt_d;
        gw_state_e              state_q;
        gw_state_e              state_d;

        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of every other flop.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync_q  <= '0;
                p_q     <= 1'b0;
                cnt_q   <= '0;
                state_q <= IDLE;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], src_irq[i]};
                p_q     <= s;
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end

        assign s    = sync_q[SYNC_STAGES-1];
        // p resets low, so an edge line already high at reset release is
        // seen as one rising edge.
        assign rise = s & ~p_q;

        assign claim_hit    = claim_vld    && (claim_id    == OWN_ID);
        assign complete_hit = complete_vld && (complete_id == OWN_ID);

        // Edge count including this cycle's rise, saturating without wrap.
        assign cnt_sat = (rise && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

        // NOTE: every output of this block is given a default first, so no
        // path leaves a signal unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_sat;
            unique case (state_q)
                IDLE: begin
                    if (src_mode[i]) begin
                        // One stored or fresh edge is consumed by this pend.
                        if (cnt_sat != '0) begin
                            state_d = PEND;
                            cnt_d   = cnt_sat - 1'b1;
                        end
                    end else if (s) begin
                        state_d = PEND;
                    end
                end
                PEND: begin
                    // A level line falling here does not withdraw the request.
                    if (claim_hit) state_d = INFL;
                end
                INFL: begin
                    if (complete_hit) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // Level sources never accumulate edges.
            if (!src_mode[i]) cnt_d = '0;
        end

        assign pending[i]  = state_q[0];
        assign inflight[i] = state_q[1];
    end : g_src

    assign irq_any = |pending;

endmodule : int_gateway

// File: tb/tb_int_gateway.sv
// -----------------------------------------------------------------------------
// tb_int_gateway
//
// Directed scenarios followed by a randomized run. Expected pending/inflight
// come from a behavioural model that tracks each source as idle / waiting /
// being serviced plus a count of remembered edges, fed by a delayed copy of
// the raw lines. Inputs change on the falling edge; outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_int_gateway;

    localparam int NSRC = 8;
    localparam int IDW  = 4;
    localparam int SS   = 2;
    localparam int EW   = 2;
    localparam int CMAX = (1 << EW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_SERV = 2;

    logic            clk;
    logic            rstn;
    logic [NSRC-1:0] src_irq;
    logic [NSRC-1:0] src_mode;
    logic            claim_vld;
    logic [IDW-1:0]  claim_id;
    logic            complete_vld;
    logic [IDW-1:0]  complete_id;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] inflight;
    logic            irq_any;

    int checks;
    int errors;

    // Behavioural model state.
    int              m_state [NSRC];
    int              m_cnt   [NSRC];
    logic [NSRC-1:0] m_hist  [0:SS];   // m_hist[0] = lines seen at last edge

    int_gateway #(
        .NSRC(NSRC), .IDW(IDW), .SYNC_STAGES(SS), .ECNT_W(EW)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .src_irq(src_irq),
        .src_mode(src_mode),
        .claim_vld(claim_vld),
        .claim_id(claim_id),
        .complete_vld(complete_vld),
        .complete_id(complete_id),
        .pending(pending),
        .inflight(inflight),
        .irq_any(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_state[i] = M_IDLE;
            m_cnt[i]   = 0;
        end
        for (int k = 0; k <= SS; k++) m_hist[k] = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [NSRC-1:0] s_v;
        logic [NSRC-1:0] p_v;
        s_v = m_hist[SS-1];
        p_v = m_hist[SS];
        for (int i = 0; i < NSRC; i++) begin
            int edges;
            edges = m_cnt[i] + ((s_v[i] && !p_v[i]) ? 1 : 0);
            if (edges > CMAX) edges = CMAX;
            case (m_state[i])
                M_IDLE: begin
                    if (src_mode[i]) begin
                        if (edges > 0) begin
                            m_state[i] = M_WAIT;
                            edges = edges - 1;
                        end
                    end else if (s_v[i]) begin
                        m_state[i] = M_WAIT;
                    end
                end
                M_WAIT: if (claim_vld && int'(claim_id) == i + 1) m_state[i] = M_SERV;
                default: if (complete_vld && int'(complete_id) == i + 1) m_state[i] = M_IDLE;
            endcase
            m_cnt[i] = src_mode[i] ? edges : 0;
        end
        for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = src_irq;
    endtask

    task automatic compare_model();
        logic [NSRC-1:0] exp_p;
        logic [NSRC-1:0] exp_f;
        exp_p = '0;
        exp_f = '0;
        for (int i = 0; i < NSRC; i++) begin
            exp_p[i] = (m_state[i] == M_WAIT);
            exp_f[i] = (m_state[i] == M_SERV);
        end
        check("model_pending",  32'(pending),  32'(exp_p));
        check("model_inflight", 32'(inflight), 32'(exp_f));
        check("model_irq_any",  32'(irq_any),  32'(|exp_p));
    endtask

    // One clock: edge, model update, compare at the falling edge, drop strobes.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
        claim_vld    = 1'b0;
        complete_vld = 1'b0;
    endtask

    task automatic do_claim(input int id);
        claim_vld = 1'b1;
        claim_id  = IDW'(id);
        step();
    endtask

    task automatic do_complete(input int id);
        complete_vld = 1'b1;
        complete_id  = IDW'(id);
        step();
    endtask

    task automatic do_both(input int cid, input int kid);
        claim_vld    = 1'b1;
        claim_id     = IDW'(cid);
        complete_vld = 1'b1;
        complete_id  = IDW'(kid);
        step();
    endtask

    // Called just after a falling edge; reset is pulsed and released before
    // the next rising edge.
    task automatic async_reset();
        #1 rstn = 1'b0;
        #1;
        check("rst_pending",  32'(pending),  32'h0);
        check("rst_inflight", 32'(inflight), 32'h0);
        check("rst_irq_any",  32'(irq_any),  32'h0);
        model_reset();
        #2 rstn = 1'b1;
    endtask

    task automatic pulse(input logic [NSRC-1:0] mask, input logic [NSRC-1:0] hold, input int n);
        for (int k = 0; k < n; k++) begin
            src_irq = mask | hold;
            step();
            src_irq = hold;
            step();
        end
    endtask

    initial begin
        int episodes;
        checks       = 0;
        errors       = 0;
        rstn         = 1'b0;
        src_irq      = '0;
        src_mode     = '0;
        claim_vld    = 1'b0;
        claim_id     = '0;
        complete_vld = 1'b0;
        complete_id  = '0;
        model_reset();

        // ---- Level source through reset release ----------------------------
        src_irq = 8'h04;
        repeat (2) @(negedge clk);
        check("reset_pending",  32'(pending),  32'h0);
        check("reset_inflight", 32'(inflight), 32'h0);
        check("reset_irq_any",  32'(irq_any),  32'h0);
        rstn = 1'b1;
        step();
        check("lvl_lat_e1", 32'(pending), 32'h00);
        step();
        check("lvl_lat_e2", 32'(pending), 32'h00);
        step();
        check("lvl_lat_e3", 32'(pending), 32'h04);
        check("lvl_irq_any", 32'(irq_any), 32'h1);
        do_claim(3);
        check("lvl_claim_p", 32'(pending),  32'h00);
        check("lvl_claim_f", 32'(inflight), 32'h04);
        do_complete(3);
        check("lvl_cmpl_f", 32'(inflight), 32'h00);
        check("lvl_cmpl_p", 32'(pending),  32'h00);
        step();
        check("lvl_repend", 32'(pending), 32'h04);
        src_irq = 8'h00;
        do_claim(3);
        step();
        step();
        do_complete(3);
        step();
        check("lvl_idle", 32'(pending | inflight), 32'h00);

        // ---- Edge counting and saturation -----------------------------------
        src_mode = 8'h01;
        pulse(8'h01, 8'h00, 5);
        repeat (3) step();
        episodes = 0;
        for (int k = 0; k < 6; k++) begin
            if (pending[0]) begin
                episodes++;
                do_claim(1);
                do_complete(1);
            end
            step();
        end
        check("edge_episodes", 32'(episodes), 32'd4);
        src_mode = 8'h00;
        step();

        // ---- Illegal requests ------------------------------------------------
        src_irq = 8'h02;
        repeat (3) step();
        check("ill_setup", 32'(pending), 32'h02);
        do_claim(0);
        check("ill_claim0_p", 32'(pending),  32'h02);
        check("ill_claim0_f", 32'(inflight), 32'h00);
        do_claim(9);
        check("ill_claim9_p", 32'(pending),  32'h02);
        check("ill_claim9_f", 32'(inflight), 32'h00);
        do_claim(4);
        check("ill_claim4_p", 32'(pending),  32'h02);
        check("ill_claim4_f", 32'(inflight), 32'h00);
        do_complete(2);
        check("ill_cmpl2_p", 32'(pending),  32'h02);
        check("ill_cmpl2_f", 32'(inflight), 32'h00);
        src_irq = 8'h00;
        do_claim(2);
        step();
        step();
        do_complete(2);
        step();

        // ---- Simultaneous handshakes ----------------------------------------
        src_irq = 8'h11;
        repeat (3) step();
        check("sim_setup", 32'(pending), 32'h11);
        do_claim(1);
        check("sim_c1_p", 32'(pending),  32'h10);
        check("sim_c1_f", 32'(inflight), 32'h01);
        src_irq = 8'h10;
        step();
        step();
        do_both(5, 1);
        check("sim_diff_f", 32'(inflight), 32'h10);
        check("sim_diff_p", 32'(pending),  32'h00);
        do_complete(5);
        step();
        check("sim_repend5", 32'(pending), 32'h10);
        do_both(5, 5);
        check("sim_same_f", 32'(inflight), 32'h10);
        check("sim_same_p", 32'(pending),  32'h00);
        src_irq = 8'h00;
        step();
        step();
        do_complete(5);
        step();

        // ---- Mid-operation reset --------------------------------------------
        src_mode = 8'h07;
        pulse(8'h07, 8'h80, 3);
        repeat (3) step();
        check("mrst_setup", 32'(pending), 32'h87);
        do_claim(1);
        do_claim(3);
        check("mrst_mix_p", 32'(pending),  32'h82);
        check("mrst_mix_f", 32'(inflight), 32'h05);
        async_reset();
        step();
        check("mrst_e1", 32'(pending), 32'h00);
        step();
        check("mrst_e2", 32'(pending), 32'h00);
        step();
        check("mrst_e3", 32'(pending), 32'h80);
        repeat (3) step();
        check("mrst_cnt_clear", 32'(pending | inflight), 32'h80);
        src_irq = 8'h00;
        do_claim(8);
        step();
        step();
        do_complete(8);
        step();
        src_mode = 8'h00;
        step();

        // ---- Mode switch clears the edge count -------------------------------
        src_mode = 8'h40;
        pulse(8'h40, 8'h00, 3);
        repeat (3) step();
        check("mode_setup", 32'(pending), 32'h40);
        do_claim(7);
        check("mode_claim", 32'(inflight), 32'h40);
        src_mode = 8'h00;
        step();
        do_complete(7);
        check("mode_cmpl", 32'(inflight), 32'h00);
        repeat (4) step();
        check("mode_no_repend", 32'(pending), 32'h00);

        // ---- Randomized traffic against the model ----------------------------
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NSRC; i++)
                if ($urandom_range(0, 3) == 0) src_irq[i] = ~src_irq[i];
            if ($urandom_range(0, 63) == 0) begin
                int j;
                j = int'($urandom_range(0, NSRC - 1));
                src_mode[j] = ~src_mode[j];
            end
            claim_vld    = 1'($urandom_range(0, 1));
            claim_id     = ($urandom_range(0, 3) == 0) ? IDW'($urandom_range(0, 15))
                                                       : IDW'($urandom_range(1, NSRC));
            complete_vld = 1'($urandom_range(0, 1));
            complete_id  = ($urandom_range(0, 3) == 0) ? IDW'($urandom_range(0, 15))
                                                       : IDW'($urandom_range(1, NSRC));
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_int_gateway
